// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: steers byte lanes onto a req/ack bus,
// freezes the pipeline while the access is outstanding and returns extended load data.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadMEM,
    input  logic        MemWriteMEM,
    input  logic [1:0]  mem_sizeMEM,
    input  logic        mem_unsignedMEM,
    input  logic [31:0] alu_outMEM,
    input  logic [31:0] wdataMEM,
    output logic        stall,
    output logic [31:0] dmem_rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q;
    logic [9:0]  cnt_q;
    logic        req_q, we_q, bus_err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;

    logic        access, misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_d, lane_shift;
    logic [15:0] half_sel;

    assign access = MemReadMEM | MemWriteMEM;

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = wdataMEM;
        unique case (mem_sizeMEM)
            2'b00: begin
                be_d    = 4'b0001 << alu_outMEM[1:0];
                wdata_d = {4{wdataMEM[7:0]}};
            end
            2'b01: begin
                misaligned = alu_outMEM[0];
                be_d       = 4'b0011 << alu_outMEM[1:0];
                wdata_d    = {2{wdataMEM[15:0]}};
            end
            default: misaligned = |alu_outMEM[1:0];
        endcase
    end

    // Inputs are frozen during WAIT, so the ack-cycle word is steered with the same address bits.
    always_comb begin
        lane_shift = dbus_rdata >> {alu_outMEM[1:0], 3'b000};
        half_sel   = alu_outMEM[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        load_d     = '0;
        if (MemReadMEM) begin
            unique case (mem_sizeMEM)
                2'b00:   load_d = mem_unsignedMEM ? {24'h0, lane_shift[7:0]}
                                                  : {{24{lane_shift[7]}}, lane_shift[7:0]};
                2'b01:   load_d = mem_unsignedMEM ? {16'h0, half_sel}
                                                  : {{16{half_sel[15]}}, half_sel};
                default: load_d = dbus_rdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            bus_err_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            be_q      <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access && !misaligned) begin
                        addr_q  <= {alu_outMEM[31:2], 2'b00};
                        we_q    <= MemWriteMEM;
                        be_q    <= MemWriteMEM ? be_d : 4'b1111;
                        wdata_q <= wdata_d;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (dbus_ack) begin
                        req_q   <= 1'b0;
                        rdata_q <= load_d;
                        state_q <= DONE;
                    end else if (cnt_q == 10'(TIMEOUT - 1)) begin
                        req_q     <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall      = !reset && ((state_q == IDLE && access && !misaligned) || state_q == WAIT);
    assign addr_err   = !reset && state_q == IDLE && access && misaligned;
    assign bus_err    = bus_err_q;
    assign dmem_rdata = (state_q == DONE) ? rdata_q : '0;
    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random loads/stores checked
// against an arithmetic model of lane steering, extension and handshake timing.
module tb_mem_access_stage;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadMEM, MemWriteMEM, mem_unsignedMEM;
    logic [1:0]  mem_sizeMEM;
    logic [31:0] alu_outMEM, wdataMEM;
    logic        stall, addr_err, bus_err, dbus_req, dbus_we, dbus_ack;
    logic [31:0] dmem_rdata, dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemReadMEM(MemReadMEM), .MemWriteMEM(MemWriteMEM),
        .mem_sizeMEM(mem_sizeMEM), .mem_unsignedMEM(mem_unsignedMEM),
        .alu_outMEM(alu_outMEM), .wdataMEM(wdataMEM),
        .stall(stall), .dmem_rdata(dmem_rdata),
        .addr_err(addr_err), .bus_err(bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % size_bytes(size)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] word);
        int unsigned off = addr % 4;
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (word >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_be(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        int unsigned off = addr % 4;
        if (!wr) return 32'hF;
        if (size == 2'd0) return 32'h1 << off;
        if (size == 2'd1) return 32'h3 << off;
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemReadMEM  = 1'b0;
            MemWriteMEM = 1'b0;
            dbus_ack    = 1'($urandom_range(0, 1));
            dbus_rdata  = $urandom;
            @(negedge clk);
            check("idle_stall", stall, 0);
            check("idle_req", dbus_req, 0);
            check("idle_addr_err", addr_err, 0);
            check("idle_bus_err", bus_err, 0);
            check("idle_rdata", dmem_rdata, 0);
        end
    endtask

    // ack_at = cycle offset of dbus_ack after the access cycle; above TO means never acked.
    task automatic access(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int unsigned ack_at, input logic [31:0] word);
        logic        mis, timed_out;
        int unsigned waited, stalls;
        @(posedge clk); #1;
        MemReadMEM      = rd;
        MemWriteMEM     = wr;
        mem_sizeMEM     = size;
        mem_unsignedMEM = uns;
        alu_outMEM      = addr;
        wdataMEM        = wd;
        dbus_ack        = 1'b0;
        mis       = m_misaligned(size, addr);
        timed_out = ack_at > TO;
        waited    = timed_out ? TO : ack_at;
        stalls    = 0;
        @(negedge clk);
        check("acc_stall", stall, !mis);
        check("acc_addr_err", addr_err, mis);
        check("acc_req", dbus_req, 0);
        check("acc_rdata", dmem_rdata, 0);
        check("acc_bus_err", bus_err, 0);
        if (stall) stalls++;
        if (mis) begin
            @(posedge clk); #1;
            MemReadMEM  = 1'b0;
            MemWriteMEM = 1'b0;
            @(negedge clk);
            check("mis_req", dbus_req, 0);
            check("mis_addr_err_pulse", addr_err, 0);
            check("mis_stall", stall, 0);
            return;
        end
        for (int unsigned c = 1; c <= waited; c++) begin
            @(posedge clk); #1;
            dbus_ack   = (c == ack_at);
            dbus_rdata = (c == ack_at) ? word : $urandom;
            @(negedge clk);
            check("wait_req", dbus_req, 1);
            check("wait_addr", dbus_addr, addr & 32'hFFFF_FFFC);
            check("wait_be", dbus_be, m_be(wr, size, addr));
            check("wait_we", dbus_we, wr);
            if (wr) check("wait_wdata", dbus_wdata, m_wdata(size, wd));
            check("wait_bus_err", bus_err, 0);
            check("wait_rdata", dmem_rdata, 0);
            if (stall) stalls++;
        end
        @(posedge clk); #1;
        dbus_ack   = 1'b0;
        dbus_rdata = $urandom;
        @(negedge clk);
        check("done_stall", stall, 0);
        check("done_req", dbus_req, 0);
        check("done_rdata", dmem_rdata, (timed_out || !rd) ? 32'h0 : m_load(size, uns, addr, word));
        check("done_bus_err", bus_err, timed_out);
        check("done_addr_err", addr_err, 0);
        check("stall_cycles", stalls, waited + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        MemReadMEM = 1'b0; MemWriteMEM = 1'b0; mem_sizeMEM = 2'd0; mem_unsignedMEM = 1'b0;
        alu_outMEM = '0; wdataMEM = '0; dbus_ack = 1'b0; dbus_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_req", dbus_req, 0);
        check("rst_we", dbus_we, 0);
        check("rst_addr", dbus_addr, 0);
        check("rst_be", dbus_be, 0);
        check("rst_wdata", dbus_wdata, 0);
        check("rst_rdata", dmem_rdata, 0);
        check("rst_errs", {addr_err, bus_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        access(1, 0, 2'd2, 0, 32'h0000_0104, 0, 1, 32'hDEAD_BEEF);
        idle(1);
        access(1, 0, 2'd0, 0, 32'h0000_0203, 0, 1, 32'h80FF_1234);
        access(1, 0, 2'd0, 1, 32'h0000_0203, 0, 1, 32'h80FF_1234);
        access(1, 0, 2'd1, 0, 32'h0000_0202, 0, 1, 32'h80FF_1234);
        idle(1);
        access(0, 1, 2'd0, 0, 32'h0000_0102, 32'h0000_00AB, 2, 0);
        access(0, 1, 2'd1, 0, 32'h0000_0102, 32'h0000_1234, 1, 0);
        idle(1);
        access(1, 0, 2'd2, 0, 32'h0000_0101, 0, 1, 0);
        access(1, 0, 2'd1, 0, 32'h0000_0103, 0, 1, 0);
        access(1, 0, 2'd2, 0, 32'h0000_0040, 0, 5, 32'h1357_9BDF);
        access(1, 0, 2'd2, 0, 32'h0000_0044, 0, TO + 5, 32'hFFFF_FFFF);
        idle(1);

        // Reset asserted in the third WAIT cycle.
        @(posedge clk); #1;
        MemReadMEM = 1'b1; MemWriteMEM = 1'b0; mem_sizeMEM = 2'd2; alu_outMEM = 32'h300;
        @(negedge clk);
        check("rw_stall_n", stall, 1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                reset = 1'b1;
                MemReadMEM = 1'b0;
            end
            @(negedge clk);
            check("rw_req_wait", dbus_req, 1);
            check("rw_stall_wait", stall, (i == 3) ? 0 : 1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        dbus_ack = 1'b1;
        @(negedge clk);
        check("rw_req", dbus_req, 0);
        check("rw_addr", dbus_addr, 0);
        check("rw_be", dbus_be, 0);
        check("rw_we", dbus_we, 0);
        check("rw_stall", stall, 0);
        check("rw_rdata", dmem_rdata, 0);
        idle(3);

        access(1, 0, 2'd2, 0, 32'h0000_0500, 0, 1, 32'h1111_2222);
        access(1, 0, 2'd2, 0, 32'h0000_0504, 0, 1, 32'h3333_4444);

        for (int t = 0; t < 40; t++) begin
            logic rd_r;
            rd_r = 1'($urandom_range(0, 1));
            access(rd_r, !rd_r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(1, TO + 2), $urandom);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
